// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, imem address and IF/ID latch with exception/ERET redirect.
// Optional fetch address check enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_valid,
  input  logic [31:0] next_pc_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        bd_D,
  output logic [4:0]  exc_code_D,
  output logic        valid_D
);

  typedef enum logic {S_RUN, S_REDIR} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc_d, w_pc_d_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        r_bd, w_bd_nxt;
  logic [4:0]  r_exc_code, w_exc_code_nxt;
  logic        r_valid, w_valid_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_fetch_instr;
  logic [4:0]  w_fetch_exc;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] IMEM_LIMIT = IMEM_BASE + (32'(IMEM_WORDS) << 2);
  logic w_fault;
  assign w_fault       = (r_pc[1:0] != 2'b00) || (r_pc < IMEM_BASE) || (r_pc >= IMEM_LIMIT);
  assign w_fetch_instr = w_fault ? 32'd0 : imem_rdata;
  assign w_fetch_exc   = w_fault ? 5'd4 : 5'd0;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = ^{IMEM_BASE, 32'(IMEM_WORDS)};
  assign w_fetch_instr = imem_rdata;
  assign w_fetch_exc   = 5'd0;
`endif

  // Redirects beat stall; npc_valid is only trusted once ID holds a real instruction (RUN).
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_pc_d_nxt     = r_pc_d;
    w_pc4_nxt      = r_pc4;
    w_bd_nxt       = r_bd;
    w_exc_code_nxt = r_exc_code;
    w_valid_nxt    = r_valid;
    if (exc_req || eret_req) begin
      w_pc_nxt       = exc_req ? EXC_ENTRY : epc;
      w_instr_nxt    = 32'd0;
      w_bd_nxt       = 1'b0;
      w_exc_code_nxt = 5'd0;
      w_valid_nxt    = 1'b0;
      w_state_nxt    = S_REDIR;
    end else if (!stall) begin
      w_instr_nxt    = w_fetch_instr;
      w_pc_d_nxt     = r_pc;
      w_pc4_nxt      = w_pc_plus4;
      w_exc_code_nxt = w_fetch_exc;
      w_valid_nxt    = 1'b1;
      w_state_nxt    = S_RUN;
      if (r_state == S_RUN && npc_valid) begin
        w_pc_nxt = next_pc_D;
        w_bd_nxt = 1'b1;
      end else begin
        w_pc_nxt = w_pc_plus4;
        w_bd_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_REDIR;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_pc_d     <= 32'd0;
      r_pc4      <= 32'd0;
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_pc_d     <= w_pc_d_nxt;
      r_pc4      <= w_pc4_nxt;
      r_bd       <= w_bd_nxt;
      r_exc_code <= w_exc_code_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign imem_addr  = r_pc;
  assign pc_F       = r_pc;
  assign instr_D    = r_instr;
  assign pc_D       = r_pc_d;
  assign pc4_D      = r_pc4;
  assign bd_D       = r_bd;
  assign exc_code_D = r_exc_code;
  assign valid_D    = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven scoreboard bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        npc_valid = 1'b0;
  logic [31:0] next_pc_D = 32'd0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc4_D;
  logic        bd_D;
  logic [4:0]  exc_code_D;
  logic        valid_D;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_valid(npc_valid),
    .next_pc_D(next_pc_D), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_F(pc_F),
    .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D), .bd_D(bd_D),
    .exc_code_D(exc_code_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  function automatic logic addr_fault(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
`else
    return 1'b0;
`endif
  endfunction

  localparam logic [3:0] S = 4'b1000, N = 4'b0100, E = 4'b0010, R = 4'b0001;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] npc;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic [31:0] pc_d;
    logic [31:0] pc4;
    logic        bd;
    logic        valid;
    logic [4:0]  exc;
  } vec_t;

  function automatic vec_t fv(input logic [3:0] ctl, input logic [31:0] npc, input logic [31:0] e,
                              input logic [31:0] pcf, input logic [31:0] src, input logic bd);
    vec_t v;
    v.ctl = ctl; v.npc = npc; v.epc = e; v.pc_f = pcf;
    v.instr = addr_fault(src) ? 32'd0 : mem_word(src);
    v.exc   = addr_fault(src) ? 5'd4 : 5'd0;
    v.pc_d = src; v.pc4 = src + 32'd4; v.bd = bd; v.valid = 1'b1;
    return v;
  endfunction

  function automatic vec_t bv(input logic [3:0] ctl, input logic [31:0] npc, input logic [31:0] e,
                              input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] pc4);
    vec_t v;
    v.ctl = ctl; v.npc = npc; v.epc = e; v.pc_f = pcf;
    v.instr = 32'd0; v.exc = 5'd0; v.pc_d = pcd; v.pc4 = pc4; v.bd = 1'b0; v.valid = 1'b0;
    return v;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int cur_row = -1;
  vec_t tbl[26];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, cur_row, act, exp);
    end
  endtask

  task automatic chk_all(input vec_t x);
    chk("pc_F", pc_F, x.pc_f);
    chk("instr_D", instr_D, x.instr);
    chk("pc_D", pc_D, x.pc_d);
    chk("pc4_D", pc4_D, x.pc4);
    chk("bd_D", 32'(bd_D), 32'(x.bd));
    chk("valid_D", 32'(valid_D), 32'(x.valid));
    chk("exc_code_D", 32'(exc_code_D), 32'(x.exc));
  endtask

  initial begin
    tbl[0]  = fv(4'b0, 32'h0, 32'h0, 32'h3004, 32'h3000, 1'b0);
    tbl[1]  = fv(4'b0, 32'h0, 32'h0, 32'h3008, 32'h3004, 1'b0);
    tbl[2]  = fv(4'b0, 32'h0, 32'h0, 32'h300C, 32'h3008, 1'b0);
    tbl[3]  = fv(N, 32'h3020, 32'h0, 32'h3020, 32'h300C, 1'b1);
    tbl[4]  = fv(4'b0, 32'h0, 32'h0, 32'h3024, 32'h3020, 1'b0);
    tbl[5]  = fv(S | N, 32'h3040, 32'h0, 32'h3024, 32'h3020, 1'b0);
    tbl[6]  = fv(S | N, 32'h3040, 32'h0, 32'h3024, 32'h3020, 1'b0);
    tbl[7]  = fv(S | N, 32'h3040, 32'h0, 32'h3024, 32'h3020, 1'b0);
    tbl[8]  = fv(N, 32'h3040, 32'h0, 32'h3040, 32'h3024, 1'b1);
    tbl[9]  = bv(E | S | N, 32'h3060, 32'h0, 32'h4180, 32'h3024, 32'h3028);
    tbl[10] = fv(N, 32'h3060, 32'h0, 32'h4184, 32'h4180, 1'b0);
    tbl[11] = bv(E | R, 32'h0, 32'h3010, 32'h4180, 32'h4180, 32'h4184);
    tbl[12] = bv(R, 32'h0, 32'h3010, 32'h3010, 32'h4180, 32'h4184);
    tbl[13] = fv(4'b0, 32'h0, 32'h0, 32'h3014, 32'h3010, 1'b0);
    tbl[14] = bv(R, 32'h0, 32'h3030, 32'h3030, 32'h3010, 32'h3014);
    tbl[15] = bv(S | N, 32'h3100, 32'h0, 32'h3030, 32'h3010, 32'h3014);
    tbl[16] = fv(N, 32'h3100, 32'h0, 32'h3034, 32'h3030, 1'b0);
    tbl[17] = fv(N, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h3034, 1'b1);
    tbl[18] = fv(4'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
    tbl[19] = fv(N, 32'h3002, 32'h0, 32'h3002, 32'h0, 1'b1);
    tbl[20] = fv(N, 32'h8000, 32'h0, 32'h8000, 32'h3002, 1'b1);
    tbl[21] = fv(N, 32'h3000, 32'h0, 32'h3000, 32'h8000, 1'b1);
    tbl[22] = fv(4'b0, 32'h0, 32'h0, 32'h3004, 32'h3000, 1'b0);
    tbl[23] = fv(N, 32'h6FFC, 32'h0, 32'h6FFC, 32'h3004, 1'b1);
    tbl[24] = fv(4'b0, 32'h0, 32'h0, 32'h7000, 32'h6FFC, 1'b0);
    tbl[25] = fv(4'b0, 32'h0, 32'h0, 32'h7004, 32'h7000, 1'b0);

    // Reset values, held across a clock edge.
    @(posedge clk); #1;
    chk_all(bv(4'b0, 32'h0, 32'h0, 32'h3000, 32'h0, 32'h0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      {stall, npc_valid, exc_req, eret_req} = tbl[i].ctl;
      next_pc_D = tbl[i].npc;
      epc = tbl[i].epc;
      sb.push_back(tbl[i]);
      @(posedge clk); #1;
      cur_row = i;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard row %0d: got empty queue expected 1 entry", i);
      end else begin
        chk_all(sb.pop_front());
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a stalled cycle, then REDIR must ignore npc_valid.
    cur_row = 100;
    {stall, npc_valid, exc_req, eret_req} = S | N;
    next_pc_D = 32'h3100;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_all(bv(4'b0, 32'h0, 32'h0, 32'h3000, 32'h0, 32'h0));
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    cur_row = 101;
    sb.push_back(fv(N, 32'h3100, 32'h0, 32'h3004, 32'h3000, 1'b0));
    @(posedge clk); #1;
    chk_all(sb.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
